// File: rtl/seq_cla_adder_ctrl.sv
// rtl/seq_cla_adder_ctrl.sv - multi-cycle adder sequencing one shared carry-lookahead slice across the operand
module seq_cla_adder_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    // Refuse to elaborate a slice width that does not tile the operand
    generate
        if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("seq_cla_adder_ctrl: WIDTH must be a multiple of SLICE and SLICE in 1..WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [KW-1:0]     k_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              cout_q;
    logic              ovf_q;

    logic              accept;
    logic              last;
    logic [31:0]       base;
    logic [SLICE-1:0]  sa;
    logic [SLICE-1:0]  sb;
    logic [SLICE-1:0]  p;
    logic [SLICE-1:0]  g;
    logic [SLICE-1:0]  s;
    logic [SLICE:0]    c;
    logic              acc;
    logic              term;

    // State register; reset parks the controller in IDLE and abandons any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last      = (k_q == KW'(N - 1));
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lookahead slice: every carry is a two-level sum of products of g/p and the slice carry-in
    always_comb begin
        base = 32'(k_q) * 32'(SLICE);
        sa   = SLICE'(a_q >> base);
        sb   = SLICE'(b_q >> base);
        p    = sa | sb;
        g    = sa & sb;
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        c[0] = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            term = carry_q;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = acc | term;
        end
        s = sa ^ sb ^ c[SLICE-1:0];
    end

    // Operand capture, per-slice result assembly and inter-pass carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            k_q     <= '0;
        end else if (state_q == RUN) begin
            sum_q   <= (sum_q & ~(SLICE_MASK << base)) | (WIDTH'(s) << base);
            carry_q <= c[SLICE];
            if (last) begin
                cout_q <= c[SLICE];
                ovf_q  <= c[SLICE-1] ^ c[SLICE];
            end else begin
                k_q <= k_q + KW'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/seq_cla_adder_ctrl.md
Name: seq_cla_adder_ctrl

Overview:
- Multi-cycle adder controller. Adds two WIDTH-bit operands over WIDTH/SLICE clock cycles using one shared SLICE-bit carry-lookahead slice.
- Each bit cell of the slice produces p = a|b, g = a&b and sum = a^b^c.
- The block sequences the slice across the operand, registers the carry between passes, and assembles the result.
- It sits between a valid/ready producer and a valid/ready consumer in the arithmetic datapath. It trades latency for area against a full-width CLA.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of SLICE, or elaboration fails.
- SLICE, 4, bits processed per cycle by the shared lookahead slice. Range 1..WIDTH.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  first term.
- b  in  WIDTH  second term.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: carry into MSB XOR cout.
- busy  out  1  high in RUN or DONE.

Behaviour:
- N = WIDTH/SLICE. Slice index k counts 0..N-1; its width is clog2(N), minimum 1.
- Registered state machine with states IDLE, RUN and DONE.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE, k = 0.
  - Carry, sum, cout, ovf and out_valid are cleared to 0. busy = 0.
  - in_ready = 1 while in IDLE, including during reset.
  - Reset mid-operation aborts the operation. No result is emitted and the operands are discarded.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1: latch a, b, cin into internal operand registers, set carry register = cin, set k = 0, go to RUN.
  - Any operand changes after acceptance are ignored.
- RUN:
  - in_ready = 0.
  - Each edge processes bits [k*SLICE +: SLICE].
  - Per bit i: p_i = a_i | b_i, g_i = a_i & b_i.
  - Lookahead carries: c_{i+1} = g_i | (p_i & c_i), flattened into two-level sum-of-products from the slice carry-in. No ripple chain.
  - Sum bit: s_i = a_i ^ b_i ^ c_i.
  - Slice sum bits are written into sum[k*SLICE +: SLICE]. The carry register takes c_SLICE.
  - When k = N-1:
    - cout takes c_SLICE and ovf takes c_{SLICE-1} ^ c_SLICE.
    - State goes to DONE and out_valid is set to 1 on that same edge.
  - Otherwise k increments.
- Latency:
  - out_valid rises exactly N edges after the accepting edge.
  - Throughput is one operation per N+2 cycles minimum: accept, N RUN cycles, one DONE cycle.
- DONE:
  - out_valid = 1. sum, cout and ovf are held stable until handshake.
  - On an edge with out_ready = 1: out_valid goes to 0 and state goes to IDLE.
  - sum, cout and ovf retain their value after handshake until the next operation overwrites them.
  - in_ready stays 0 in DONE, so there is no same-cycle accept on result handoff.
- Backpressure: out_ready may stay low indefinitely. The block stays in DONE with all outputs frozen.
- in_valid while not in IDLE is ignored. The producer must hold it until in_ready.
- N = 1 (WIDTH = SLICE): RUN lasts one cycle and out_valid rises one edge after acceptance.
- During RUN, the sum bits of slices not yet processed are don't-care and must not be relied on. Only sample sum when out_valid = 1.
- ovf = 0 whenever cout and the carry into the MSB match. Both outputs are pure functions of the completed operation.

Test Plan:
- Reset mid-RUN: accept a=0x1234, b=0x1111, assert rst_n=0 after 2 edges. Required: in_ready=1, out_valid=0, busy=0, sum=0 immediately. After release, accept a=0x0001, b=0x0001, cin=0 → sum=0x0002.
- Full carry propagation: a=0xFFFF, b=0x0001, cin=0 → out_valid exactly 4 edges after accept, sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Carry-in: a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0. a=0, b=0, cin=1 → sum=0x0001.
- Backpressure and stability: hold out_ready=0 for 10 cycles after out_valid with a=0x1234, b=0x4321 → sum=0x5555 stable and in_ready=0 throughout. Toggle a/b/in_valid meanwhile with no effect. out_ready=1 → out_valid drops next edge and in_ready=1.
- Parameter sweep: WIDTH=8 with SLICE=1, 4 and 8 → latency 8, 2 and 1 edges respectively. Compare 256 random operand/cin triples against a reference sum.
